embedding_seq_ctrl: RTL and testbench

EMBEDDING_SEQ_CTRL -- requirements
Module: embedding_seq_ctrl

---
 rtl/embedding_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_embedding_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/embedding_seq_ctrl.sv
// -----------------------------------------------------------------------------
// embedding_seq_ctrl
//   Sequencing controller for a token + position embedding lookup unit.
//   In IDLE it grants table writes from a loader (load has priority over
//   tokens). It accepts one token at a time, issues a single-cycle lookup,
//   waits for the result and holds it on a valid/ready output stream. The
//   position counter advances on each output handshake. When position
//   MAX_SEQ_LEN-1 has been delivered the counter wraps and seq_full is set.
//   seq_full clears on the next seq_start.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   seq_start             begin new sequence (only honoured in IDLE)
//   busy, seq_full        status
//   tok_valid/ready/id    token input stream
//   ld_req/gnt/sel/idx/dim/data   table-write requester (sel 0=token, 1=pos)
//   lk_load_*             lookup-table write port (combinational pass-through)
//   lk_valid_in, lk_token_id, lk_position, lk_emb_out, lk_valid_out
//                         lookup inference port
//   emb_valid/ready/data/pos/last  downstream embedding stream
//   stat_tokens, stat_stall        statistics
//
// Configuration
//   EMB_SEQ_CTRL_STATS_EN  when defined, enables the saturating statistics
//                          counters; otherwise both stat outputs read 0.
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | table loads granted, waiting for a token or seq_start
//   S_ISSUE | lk_valid_in high for one cycle
//   S_WAIT  | waiting for lk_valid_out from the lookup unit
//   S_OUT   | emb_valid high, holding result until emb_ready
// -----------------------------------------------------------------------------
module embedding_seq_ctrl #(
  parameter int VOCAB_SIZE  = 16,
  parameter int MAX_SEQ_LEN = 8,
  parameter int EMBED_DIM   = 4,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              seq_start,
  output logic                              busy,
  output logic                              seq_full,
  input  logic                              tok_valid,
  output logic                              tok_ready,
  input  logic [$clog2(VOCAB_SIZE)-1:0]     tok_id,
  input  logic                              ld_req,
  output logic                              ld_gnt,
  input  logic                              ld_sel,
  input  logic [$clog2(VOCAB_SIZE)-1:0]     ld_idx,
  input  logic [$clog2(EMBED_DIM)-1:0]      ld_dim,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  output logic                              lk_load_token_emb,
  output logic                              lk_load_pos_emb,
  output logic [$clog2(VOCAB_SIZE)-1:0]     lk_load_token_idx,
  output logic [$clog2(MAX_SEQ_LEN)-1:0]    lk_load_pos_idx,
  output logic [$clog2(EMBED_DIM)-1:0]      lk_load_dim_idx,
  output logic [DATA_WIDTH-1:0]             lk_load_data,
  output logic                              lk_valid_in,
  output logic [$clog2(VOCAB_SIZE)-1:0]     lk_token_id,
  output logic [$clog2(MAX_SEQ_LEN)-1:0]    lk_position,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0]   lk_emb_out,
  input  logic                              lk_valid_out,
  output logic                              emb_valid,
  input  logic                              emb_ready,
  output logic [EMBED_DIM*DATA_WIDTH-1:0]   emb_data,
  output logic [$clog2(MAX_SEQ_LEN)-1:0]    emb_pos,
  output logic                              emb_last,
  output logic [15:0]                       stat_tokens,
  output logic [15:0]                       stat_stall
);

  localparam int PW = $clog2(MAX_SEQ_LEN);
  localparam logic [PW-1:0] LAST_POS = PW'(MAX_SEQ_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t        state;
  logic [PW-1:0] position;
  logic          in_idle;
  logic          start_ok;
  logic          tok_acc;
  logic          emb_hs;

  assign in_idle  = (state == S_IDLE);
  assign busy     = ~in_idle;
  assign start_ok = rst_n & in_idle & seq_start;
  assign emb_hs   = (state == S_OUT) & emb_ready;

  // Combinational handshakes are gated with rst_n so every output reads 0
  // while reset is held, even though the state register already reads IDLE.
  assign ld_gnt = rst_n & in_idle & ld_req;

  // seq_start wins over a token in the same cycle, so ready drops rather than
  // signalling an acceptance that would not happen.
  assign tok_ready = rst_n & in_idle & ~ld_req & ~seq_full & ~seq_start;
  assign tok_acc   = tok_valid & tok_ready;

  assign lk_load_token_emb = ld_gnt & ~ld_sel;
  assign lk_load_pos_emb   = ld_gnt & ld_sel;
  assign lk_load_token_idx = ld_gnt ? ld_idx : '0;
  assign lk_load_pos_idx   = ld_gnt ? ld_idx[PW-1:0] : '0;
  assign lk_load_dim_idx   = ld_gnt ? ld_dim : '0;
  assign lk_load_data      = ld_gnt ? ld_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      position    <= '0;
      seq_full    <= 1'b0;
      lk_valid_in <= 1'b0;
      lk_token_id <= '0;
      lk_position <= '0;
      emb_valid   <= 1'b0;
      emb_data    <= '0;
      emb_pos     <= '0;
      emb_last    <= 1'b0;
    end else begin
      lk_valid_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            position <= '0;
            seq_full <= 1'b0;
          end else if (tok_acc) begin
            lk_token_id <= tok_id;
            lk_position <= position;
            lk_valid_in <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (lk_valid_out) begin
            emb_data  <= lk_emb_out;
            emb_pos   <= lk_position;
            emb_last  <= (lk_position == LAST_POS);
            emb_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (emb_ready) begin
            emb_valid <= 1'b0;
            state     <= S_IDLE;
            if (emb_pos == LAST_POS) begin
              position <= '0;
              seq_full <= 1'b1;
            end else begin
              position <= position + PW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef EMB_SEQ_CTRL_STATS_EN
  logic [15:0] stat_tokens_q;
  logic [15:0] stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_tokens_q <= '0;
      stat_stall_q  <= '0;
    end else if (start_ok) begin
      stat_tokens_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (emb_hs && (stat_tokens_q != 16'hFFFF))
        stat_tokens_q <= stat_tokens_q + 16'd1;
      if ((state == S_OUT) && !emb_ready && (stat_stall_q != 16'hFFFF))
        stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_tokens = stat_tokens_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_tokens = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_embedding_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_embedding_seq_ctrl
//   Directed bench for embedding_seq_ctrl. A small behavioural lookup unit
//   holds the token/position tables (written through the lk_load_* port, never
//   reset) and answers each lk_valid_in one cycle later with the lane-wise sum.
//   Expected embeddings come from the table constants below.
// -----------------------------------------------------------------------------
module tb_embedding_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        seq_start;
  logic        busy;
  logic        seq_full;
  logic        tok_valid;
  logic        tok_ready;
  logic [3:0]  tok_id;
  logic        ld_req;
  logic        ld_gnt;
  logic        ld_sel;
  logic [3:0]  ld_idx;
  logic [1:0]  ld_dim;
  logic [15:0] ld_data;
  logic        lk_load_token_emb;
  logic        lk_load_pos_emb;
  logic [3:0]  lk_load_token_idx;
  logic [2:0]  lk_load_pos_idx;
  logic [1:0]  lk_load_dim_idx;
  logic [15:0] lk_load_data;
  logic        lk_valid_in;
  logic [3:0]  lk_token_id;
  logic [2:0]  lk_position;
  logic [63:0] lk_emb_out;
  logic        lk_valid_out;
  logic        emb_valid;
  logic        emb_ready;
  logic [63:0] emb_data;
  logic [2:0]  emb_pos;
  logic        emb_last;
  logic [15:0] stat_tokens;
  logic [15:0] stat_stall;

  int n_vec = 0;
  int n_err = 0;

  embedding_seq_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .seq_start         (seq_start),
    .busy              (busy),
    .seq_full          (seq_full),
    .tok_valid         (tok_valid),
    .tok_ready         (tok_ready),
    .tok_id            (tok_id),
    .ld_req            (ld_req),
    .ld_gnt            (ld_gnt),
    .ld_sel            (ld_sel),
    .ld_idx            (ld_idx),
    .ld_dim            (ld_dim),
    .ld_data           (ld_data),
    .lk_load_token_emb (lk_load_token_emb),
    .lk_load_pos_emb   (lk_load_pos_emb),
    .lk_load_token_idx (lk_load_token_idx),
    .lk_load_pos_idx   (lk_load_pos_idx),
    .lk_load_dim_idx   (lk_load_dim_idx),
    .lk_load_data      (lk_load_data),
    .lk_valid_in       (lk_valid_in),
    .lk_token_id       (lk_token_id),
    .lk_position       (lk_position),
    .lk_emb_out        (lk_emb_out),
    .lk_valid_out      (lk_valid_out),
    .emb_valid         (emb_valid),
    .emb_ready         (emb_ready),
    .emb_data          (emb_data),
    .emb_pos           (emb_pos),
    .emb_last          (emb_last),
    .stat_tokens       (stat_tokens),
    .stat_stall        (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural lookup unit: tables survive reset, one-cycle response.
  logic [15:0] tok_tbl [16][4];
  logic [15:0] pos_tbl [8][4];

  initial begin
    lk_valid_out = 1'b0;
    lk_emb_out   = '0;
  end

  always @(posedge clk) begin
    if (lk_load_token_emb) tok_tbl[lk_load_token_idx][lk_load_dim_idx] <= lk_load_data;
    if (lk_load_pos_emb)   pos_tbl[lk_load_pos_idx][lk_load_dim_idx]   <= lk_load_data;
    lk_valid_out <= lk_valid_in;
    for (int d = 0; d < 4; d++)
      lk_emb_out[d*16 +: 16] <= tok_tbl[lk_token_id][d] + pos_tbl[lk_position][d];
  end

  function automatic logic [15:0] tok_val(input int t, input int d);
    if (t == 5) return 16'h0100;
    return 16'(16'h0200 + d);
  endfunction

  function automatic logic [15:0] pos_val(input int p);
    if (p == 0) return 16'h0080;
    return 16'(16'h0010 * p);
  endfunction

  function automatic logic [63:0] exp_emb(input int t, input int p);
    logic [63:0] r;
    for (int d = 0; d < 4; d++) r[d*16 +: 16] = 16'(tok_val(t, d) + pos_val(p));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic sel, input int idx, input int dim, input logic [15:0] data);
    ld_req  = 1'b1;
    ld_sel  = sel;
    ld_idx  = 4'(idx);
    ld_dim  = 2'(dim);
    ld_data = data;
    step();
  endtask

  // One token through the pipeline: accept at T, check lk_valid_in at T+1,
  // emb_valid at T+3, optionally stall OUT, optionally pulse seq_start on the
  // handshake cycle.
  task automatic run_tok(input int id, input int pos, input int stall, input bit start_in_out);
    logic [63:0] e;
    e = exp_emb(id, pos);
    emb_ready = 1'b0;
    tok_valid = 1'b1;
    tok_id    = 4'(id);
    #1;
    chk("tok_ready_T", tok_ready, 1);
    step();
    tok_valid = 1'b0;
    chk("lk_valid_in_T1", lk_valid_in, 1);
    chk("lk_token_id", lk_token_id, id);
    chk("lk_position", lk_position, pos);
    step();
    chk("lk_valid_in_T2", lk_valid_in, 0);
    chk("emb_valid_T2", emb_valid, 0);
    step();
    chk("emb_valid_T3", emb_valid, 1);
    chk("emb_data", emb_data, e);
    chk("emb_pos", emb_pos, pos);
    chk("emb_last", emb_last, (pos == 7));
    for (int i = 0; i < stall; i++) begin
      ld_req    = 1'b1;
      tok_valid = 1'b1;
      #1;
      chk("stall_ld_gnt", ld_gnt, 0);
      chk("stall_tok_ready", tok_ready, 0);
      chk("stall_emb_data", emb_data, e);
      ld_req    = 1'b0;
      tok_valid = 1'b0;
      step();
    end
    emb_ready = 1'b1;
    seq_start = start_in_out;
    step();
    emb_ready = 1'b0;
    seq_start = 1'b0;
    chk("post_hs_emb_valid", emb_valid, 0);
    chk("post_hs_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b1; seq_start = 1'b0; tok_valid = 1'b0; tok_id = '0;
    ld_req = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_dim = '0; ld_data = '0;
    emb_ready = 1'b0;
    #2 rst_n = 1'b0;
    ld_req = 1'b1; tok_valid = 1'b1;
    step(); step();
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_strobe", lk_load_token_emb, 0);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_emb_valid", emb_valid, 0);
    chk("rst_emb_data", emb_data, 0);
    chk("rst_lk_valid_in", lk_valid_in, 0);
    chk("rst_seq_full", seq_full, 0);
    chk("rst_stat_tokens", stat_tokens, 0);
    ld_req = 1'b0; tok_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_tok_ready", tok_ready, 1);

    // Table load beats a pending token.
    tok_valid = 1'b1; tok_id = 4'd7;
    ld_req = 1'b1; ld_sel = 1'b0; ld_idx = 4'd3; ld_dim = 2'd1; ld_data = 16'h0100;
    #1;
    chk("ld_gnt", ld_gnt, 1);
    chk("ld_tok_strobe", lk_load_token_emb, 1);
    chk("ld_pos_strobe", lk_load_pos_emb, 0);
    chk("ld_tok_idx", lk_load_token_idx, 3);
    chk("ld_dim_idx", lk_load_dim_idx, 1);
    chk("ld_data", lk_load_data, 16'h0100);
    chk("ld_tok_ready", tok_ready, 0);
    step();
    tok_valid = 1'b0;
    chk("ld_stay_idle", busy, 0);

    // Back-to-back table writes.
    for (int d = 0; d < 4; d++) ld_write(1'b0, 5, d, tok_val(5, d));
    for (int d = 0; d < 4; d++) ld_write(1'b0, 2, d, tok_val(2, d));
    for (int p = 0; p < 8; p++)
      for (int d = 0; d < 4; d++) begin
        ld_req = 1'b1; ld_sel = 1'b1; ld_idx = 4'(p); ld_dim = 2'(d); ld_data = pos_val(p);
        if (p == 6 && d == 2) begin
          #1;
          chk("ld_pos_strobe_b2b", lk_load_pos_emb, 1);
          chk("ld_pos_idx", lk_load_pos_idx, 6);
        end
        step();
      end
    ld_req = 1'b0;

    // seq_start with a token in the same cycle: start applied, token refused.
    seq_start = 1'b1; tok_valid = 1'b1; tok_id = 4'd5;
    #1;
    chk("start_tok_ready", tok_ready, 0);
    step();
    seq_start = 1'b0; tok_valid = 1'b0;
    chk("start_no_accept", busy, 0);

    // Full sequence: token 5 at position 0 gives 0x0180 in every lane.
    run_tok(5, 0, 0, 1'b0);
    chk("pos0_lanes", exp_emb(5, 0), 64'h0180_0180_0180_0180);
    for (int p = 1; p < 8; p++) run_tok((p % 2) ? 2 : 5, p, 0, 1'b0);
    chk("seq_full_set", seq_full, 1);
    tok_valid = 1'b1;
    #1;
    chk("full_tok_ready", tok_ready, 0);
    step();
    tok_valid = 1'b0;
    chk("full_no_accept", busy, 0);

    seq_start = 1'b1;
    step();
    seq_start = 1'b0;
    chk("seq_full_clr", seq_full, 0);

    // Stall OUT for 5 cycles.
    run_tok(2, 0, 5, 1'b0);
`ifdef EMB_SEQ_CTRL_STATS_EN
    chk("stat_stall", stat_stall, 5);
    chk("stat_tokens", stat_tokens, 1);
`else
    chk("stat_stall", stat_stall, 0);
    chk("stat_tokens", stat_tokens, 0);
`endif

    // seq_start during OUT is ignored.
    run_tok(5, 1, 0, 1'b1);
    run_tok(2, 2, 0, 1'b0);
`ifdef EMB_SEQ_CTRL_STATS_EN
    chk("stat_tokens_3", stat_tokens, 3);
`else
    chk("stat_tokens_3", stat_tokens, 0);
`endif

    // Reset while waiting for the lookup result.
    tok_valid = 1'b1; tok_id = 4'd2;
    step();
    tok_valid = 1'b0;
    chk("rw_issue", lk_valid_in, 1);
    step();
    chk("rw_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_emb_valid", emb_valid, 0);
    chk("rw_tok_ready", tok_ready, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rw_rel_tok_ready", tok_ready, 1);
    chk("rw_stat_tokens", stat_tokens, 0);
    run_tok(2, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
